register_collector: RTL and testbench

//  Serial-in/parallel-out word collector; the receive-side counterpart of the shift-out register chain.

---
 rtl/register_collector.sv | 100 ++++++++++
 tb/tb_register_collector.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_collector.sv
// Serial-in/parallel-out word collector: packs `length` words of `bits` each into one frame
// and hands the frame downstream over a valid/ready handshake, sustaining one word per clock.
module register_collector #(
    parameter int unsigned bits   = 4,
    parameter int unsigned length = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [bits-1:0]                  in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [bits*length-1:0]           out_data,
    output logic [$clog2(length+1)-1:0]      count
);

    localparam int unsigned count_w = $clog2(length + 1);
    localparam int unsigned frame_w = bits * length;
    localparam logic [count_w-1:0] last_slot = count_w'(length - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [count_w-1:0]   count_next;
    logic                 out_valid_next;
    logic [frame_w-1:0]   out_data_next;

    // A held frame blocks new words unless the consumer takes it in the same cycle.
    assign in_ready = (state == FILL) | out_ready;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
        end
    end

    // Next-state, slot write and handshake decisions.
    always_comb begin
        state_next     = state;
        count_next     = count;
        out_valid_next = out_valid;
        out_data_next  = out_data;

        if (clear) begin
            // Discard the partial or held frame; slot contents are left as they are.
            state_next     = FILL;
            count_next     = '0;
            out_valid_next = 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < length; k++) begin
                            if (count == count_w'(k)) begin
                                out_data_next[k*bits +: bits] = in_data;
                            end
                        end
                        count_next = count + count_w'(1);
                        if (count == last_slot) begin
                            state_next     = FULL;
                            out_valid_next = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_next     = FILL;
                        out_valid_next = 1'b0;
                        if (in_valid) begin
                            // Frame leaves and the next frame's first word lands together.
                            out_data_next[bits-1:0] = in_data;
                            count_next              = count_w'(1);
                        end else begin
                            count_next = '0;
                        end
                    end
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_collector.sv
// Self-checking bench for register_collector (bits=4, length=4): directed scenarios plus
// randomized traffic checked against a frame-level reference model.
module tb_register_collector;

    localparam int unsigned BITS = 4;
    localparam int unsigned LEN  = 4;

    logic                   clk;
    logic                   reset;
    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [BITS-1:0]        in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITS*LEN-1:0]    out_data;
    logic [2:0]             count;

    int n_cmp;
    int n_err;

    // Reference model: words held in the frame, whether a frame is on offer, slot contents.
    int              m_count;
    bit              m_full;
    logic [BITS-1:0] m_slot [LEN];

    register_collector #(.bits(BITS), .length(LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BITS*LEN-1:0] m_frame();
        logic [BITS*LEN-1:0] f;
        f = '0;
        for (int k = 0; k < int'(LEN); k++) f[k*BITS +: BITS] = m_slot[k];
        return f;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_full  = 1'b0;
        for (int k = 0; k < int'(LEN); k++) m_slot[k] = '0;
    endtask

    // One clock: drive inputs at the falling edge, sample in_ready, then apply the frame rules.
    task automatic step(input logic v, input logic [BITS-1:0] d, input logic r,
                        input logic c, output logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        #1;
        rdy = in_ready;
        @(posedge clk);
        if (c) begin
            m_count = 0;
            m_full  = 1'b0;
        end else if (!m_full) begin
            if (v) begin
                m_slot[m_count] = d;
                m_count++;
                if (m_count == int'(LEN)) m_full = 1'b1;
            end
        end else if (r) begin
            m_full  = 1'b0;
            m_count = 0;
            if (v) begin
                m_slot[0] = d;
                m_count   = 1;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        clear = 0; in_valid = 0; in_data = 0; out_ready = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: count=%0d out_valid=%b out_data=%h, want 0/0/0000",
                     count, out_valid, out_data);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_fill();
        logic rdy;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0, rdy);
            if (i == 3) begin
                n_cmp++;
                if (out_valid !== 1'b0 || count !== 3'd3) begin
                    n_err++;
                    $display("FAIL fill_partial: out_valid=%b count=%0d want 0/3", out_valid, count);
                end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321 || count !== 3'd4) begin
            n_err++;
            $display("FAIL fill_complete: out_valid=%b out_data=%h count=%0d want 1/4321/4",
                     out_valid, out_data, count);
        end
    endtask

    task automatic test_stall();
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h5, 1'b0, 1'b0, rdy);
            n_cmp++;
            if (rdy !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready: cycle %0d got %b want 0", i, rdy);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'h4321 || count !== 3'd4) begin
                n_err++;
                $display("FAIL stall_hold: out_valid=%b out_data=%h count=%0d want 1/4321/4",
                         out_valid, out_data, count);
            end
        end
    endtask

    task automatic test_pass_through();
        logic rdy;
        step(1'b1, 4'h9, 1'b1, 1'b0, rdy);
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL pass_in_ready: got %b want 1", rdy);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd1 || out_data !== 16'h4329) begin
            n_err++;
            $display("FAIL pass_take: out_valid=%b count=%0d out_data=%h want 0/1/4329",
                     out_valid, count, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        int   stalls;
        step(1'b0, 4'h0, 1'b0, 1'b1, rdy);
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'(i), 1'b1, 1'b0, rdy);
            if (rdy !== 1'b1) stalls++;
            if (i == 4) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
                    n_err++;
                    $display("FAIL b2b_frame0: out_valid=%b out_data=%h want 1/4321", out_valid, out_data);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (out_valid !== 1'b0 || count !== 3'd1) begin
                    n_err++;
                    $display("FAIL b2b_restart: out_valid=%b count=%0d want 0/1", out_valid, count);
                end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765 || count !== 3'd4) begin
            n_err++;
            $display("FAIL b2b_frame1: out_valid=%b out_data=%h count=%0d want 1/8765/4",
                     out_valid, out_data, count);
        end
        n_cmp++;
        if (stalls != 0) begin
            n_err++;
            $display("FAIL b2b_stalls: got %0d stall cycles want 0", stalls);
        end
        step(1'b0, 4'h0, 1'b1, 1'b0, rdy);
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL take_only: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_clear();
        logic rdy;
        step(1'b1, 4'h1, 1'b0, 1'b0, rdy);
        step(1'b1, 4'h2, 1'b0, 1'b0, rdy);
        // clear wins over a same-cycle word
        step(1'b1, 4'hE, 1'b0, 1'b1, rdy);
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h8721) begin
            n_err++;
            $display("FAIL clear_discard: count=%0d out_valid=%b out_data=%h want 0/0/8721",
                     count, out_valid, out_data);
        end
        step(1'b1, 4'hA, 1'b0, 1'b0, rdy);
        step(1'b1, 4'hB, 1'b0, 1'b0, rdy);
        step(1'b1, 4'hC, 1'b0, 1'b0, rdy);
        step(1'b1, 4'hD, 1'b0, 1'b0, rdy);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'hDCBA || count !== 3'd4) begin
            n_err++;
            $display("FAIL clear_refill: out_valid=%b out_data=%h count=%0d want 1/DCBA/4",
                     out_valid, out_data, count);
        end
        // clear also drops a held frame and ignores a same-cycle take
        step(1'b1, 4'h7, 1'b1, 1'b1, rdy);
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 16'hDCBA) begin
            n_err++;
            $display("FAIL clear_full: out_valid=%b count=%0d out_data=%h want 0/0/DCBA",
                     out_valid, count, out_data);
        end
    endtask

    task automatic test_async_reset();
        logic rdy;
        step(1'b1, 4'h3, 1'b0, 1'b0, rdy);
        step(1'b1, 4'h4, 1'b0, 1'b0, rdy);
        step(1'b1, 4'h5, 1'b0, 1'b0, rdy);
        n_cmp++;
        if (count !== 3'd3) begin
            n_err++;
            $display("FAIL async_pre: count=%0d want 3", count);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset: count=%0d out_valid=%b out_data=%h want 0/0/0000",
                     count, out_valid, out_data);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        step(1'b1, 4'h6, 1'b0, 1'b0, rdy);
        n_cmp++;
        if (count !== 3'd1 || out_data !== 16'h0006) begin
            n_err++;
            $display("FAIL async_slot0: count=%0d out_data=%h want 1/0006", count, out_data);
        end
    endtask

    task automatic test_random();
        logic            rdy;
        logic            v, r, c;
        logic [BITS-1:0] d;
        logic            exp_rdy;
        int              errs;
        errs = 0;
        for (int i = 0; i < 500; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) != 0);
            c = 1'($urandom_range(0, 24) == 0);
            d = 4'($urandom);
            exp_rdy = !m_full || r;
            step(v, d, r, c, rdy);
            n_cmp++;
            if (rdy !== exp_rdy || count !== 3'(m_count) || out_valid !== m_full ||
                out_data !== m_frame()) begin
                n_err++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: in_ready=%b count=%0d out_valid=%b out_data=%h want %b/%0d/%b/%h",
                             i, rdy, count, out_valid, out_data, exp_rdy, m_count, m_full, m_frame());
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_stall();
        test_pass_through();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
